// File: rtl/alu16_if.sv
// Operand/result bundle between the execute stage and the registered ALU.
// No valid/ready: every rising clk edge accepts A/B/cin/op and result/cout show it one edge later.
interface alu16_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             cin;
  logic [3:0]       op;
  logic [WIDTH-1:0] result;
  logic             cout;

  modport master (
    output A, B, cin, op,
    input  result, cout
  );

  modport slave (
    input  A, B, cin, op,
    output result, cout
  );
endinterface

// File: rtl/alu16.sv
// Registered 16-operation ALU: combinational opcode select, one-cycle registered result/carry.
module alu16 #(
  parameter int WIDTH = 16
) (
  input  logic     clk,
  input  logic     rst,
  alu16_if.slave   bus
);

  localparam int SHW = $clog2(WIDTH);

  logic [SHW-1:0]     w_sh;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH-1:0] w_rot;
  logic [WIDTH-1:0]   w_result;
  logic               w_cout;
  logic [WIDTH-1:0]   r_result;
  logic               r_cout;

  assign w_sh   = bus.B[SHW-1:0];
  assign w_sum  = {1'b0, bus.A} + {1'b0, bus.B} + {{WIDTH{1'b0}}, bus.cin};
  // Bit WIDTH of the wrapped 17-bit difference is the borrow (A < B + cin).
  assign w_diff = {1'b0, bus.A} - {1'b0, bus.B} - {{WIDTH{1'b0}}, bus.cin};
  assign w_rot  = {bus.A, bus.A} << w_sh;

  always_comb begin
    w_result = '0;
    w_cout   = 1'b0;
    case (bus.op)
      4'd0:  {w_cout, w_result} = w_sum;
      4'd1:  {w_cout, w_result} = w_diff;
      4'd2:  w_result = bus.A & bus.B;
      4'd3:  w_result = bus.A | bus.B;
      4'd4:  w_result = bus.A ^ bus.B;
      4'd5:  w_result = bus.A << w_sh;
      4'd6:  w_result = bus.A >> w_sh;
      4'd7:  w_result = {{(WIDTH-1){1'b0}}, (bus.A < bus.B)};
      4'd8:  w_result = ~(bus.A | bus.B);
      4'd9:  w_result = ~(bus.A & bus.B);
      4'd10: w_result = ~(bus.A ^ bus.B);
      4'd11: w_result = ~bus.A;
      4'd12: w_result = $unsigned($signed(bus.A) >>> w_sh);
      4'd13: w_result = w_rot[2*WIDTH-1:WIDTH];
      4'd14: w_result = bus.A;
      4'd15: w_result = bus.B;
      default: begin
        w_result = '0;
        w_cout   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_result <= '0;
      r_cout   <= 1'b0;
    end else begin
      r_result <= w_result;
      r_cout   <= w_cout;
    end
  end

  assign bus.result = r_result;
  assign bus.cout   = r_cout;

endmodule

// File: tb/tb_alu16.sv
// Directed self-checking bench for alu16: driver pushes {cout,result} expectations, negedge monitor pops.
module tb_alu16;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SHL  = 4'd5;
  localparam logic [3:0] OP_SHR  = 4'd6;
  localparam logic [3:0] OP_SLTU = 4'd7;
  localparam logic [3:0] OP_NOR  = 4'd8;
  localparam logic [3:0] OP_NAND = 4'd9;
  localparam logic [3:0] OP_XNOR = 4'd10;
  localparam logic [3:0] OP_NOT  = 4'd11;
  localparam logic [3:0] OP_SRA  = 4'd12;
  localparam logic [3:0] OP_ROL  = 4'd13;
  localparam logic [3:0] OP_PASA = 4'd14;
  localparam logic [3:0] OP_PASB = 4'd15;

  logic clk;
  logic rst;
  logic tb_vld;
  logic cap;
  int   n_checks;
  int   n_pass;

  logic [16:0] exp_q[$];
  string       name_q[$];

  alu16_if #(.WIDTH(16)) bus ();

  alu16 #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h", name, act, exp);
    else
      n_pass++;
  endtask

  // drivers
  task automatic drive(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic cin, input logic [15:0] exp_r, input logic exp_c,
                       input string name);
    bus.op  = op;
    bus.A   = a;
    bus.B   = b;
    bus.cin = cin;
    tb_vld  = 1'b1;
    exp_q.push_back({exp_c, exp_r});
    name_q.push_back(name);
  endtask

  task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic cin, input logic [15:0] exp_r, input logic exp_c,
                       input string name);
    @(negedge clk);
    drive(op, a, b, cin, exp_r, exp_c, name);
  endtask

  task automatic idle();
    @(negedge clk);
    tb_vld = 1'b0;
  endtask

  // scoreboard monitor: cap marks an edge that captured a scored operation
  always @(posedge clk or posedge rst) begin
    if (rst) cap <= 1'b0;
    else     cap <= tb_vld;
  end

  always @(negedge clk) begin
    if (cap) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL underflow: got output with %0d queued expected >0", exp_q.size());
      end else begin
        logic [16:0] e;
        string       nm;
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        check(nm, {15'd0, bus.cout, bus.result}, {15'd0, e});
      end
    end
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    tb_vld   = 1'b0;
    rst      = 1'b0;
    bus.A    = 16'd24;
    bus.B    = 16'd35;
    bus.op   = OP_ADD;
    bus.cin  = 1'b0;
    #1 rst = 1'b1;
    #1 check("reset_async", {15'd0, bus.cout, bus.result}, 32'd0);

    @(negedge clk);
    rst = 1'b0;
    drive(OP_ADD, 16'd24, 16'd35, 1'b0, 16'd59, 1'b0, "post_reset_add");

    // arithmetic
    issue(OP_ADD, 16'd24,   16'd35, 1'b0, 16'd59,   1'b0, "add_24_35");
    issue(OP_SUB, 16'd56,   16'd18, 1'b0, 16'd38,   1'b0, "sub_56_18");
    issue(OP_ADD, 16'hFFFF, 16'd0,  1'b1, 16'h0000, 1'b1, "add_ffff_cin");
    issue(OP_SUB, 16'd5,    16'd7,  1'b0, 16'hFFFE, 1'b1, "sub_5_7");
    issue(OP_ADD, 16'hFFFF, 16'd1,  1'b0, 16'h0000, 1'b1, "add_wrap");
    issue(OP_SUB, 16'd0,    16'd1,  1'b0, 16'hFFFF, 1'b1, "sub_0_1");
    issue(OP_SUB, 16'd10,   16'd3,  1'b1, 16'd6,    1'b0, "sub_cin");
    issue(OP_SUB, 16'd4,    16'd3,  1'b1, 16'd0,    1'b0, "sub_eq_cin");
    issue(OP_SUB, 16'd3,    16'd3,  1'b1, 16'hFFFF, 1'b1, "sub_borrow_cin");

    // logic
    issue(OP_AND, 16'd96,    16'd80,  1'b0, 16'd64,   1'b0, "and_96_80");
    issue(OP_OR,  16'd51,    16'd26,  1'b0, 16'd59,   1'b0, "or_51_26");
    issue(OP_XOR, 16'd128,   16'd128, 1'b0, 16'd0,    1'b0, "xor_128");
    issue(OP_NOR, 16'd0,     16'd0,   1'b0, 16'hFFFF, 1'b0, "nor_0_0");
    issue(OP_NOT, 16'h00FF,  16'd0,   1'b0, 16'hFF00, 1'b0, "not_00ff");

    // shifts / compare, including sh=0 passthrough
    issue(OP_SHL,  16'd64,   16'd15, 1'b0, 16'd0,    1'b0, "shl_64_15");
    issue(OP_SHL,  16'd1,    16'd4,  1'b0, 16'd16,   1'b0, "shl_1_4");
    issue(OP_SHR,  16'd74,   16'd35, 1'b0, 16'd9,    1'b0, "shr_74_35");
    issue(OP_SRA,  16'h8000, 16'd4,  1'b0, 16'hF800, 1'b0, "sra_8000_4");
    issue(OP_ROL,  16'h8001, 16'd1,  1'b0, 16'h0003, 1'b0, "rol_8001_1");
    issue(OP_SLTU, 16'd24,   16'd75, 1'b0, 16'd1,    1'b0, "sltu_lt");
    issue(OP_SLTU, 16'd75,   16'd24, 1'b0, 16'd0,    1'b0, "sltu_gt");
    issue(OP_SLTU, 16'd75,   16'd75, 1'b0, 16'd0,    1'b0, "sltu_eq");
    issue(OP_SHL,  16'h1234, 16'h0010, 1'b0, 16'h1234, 1'b0, "shl_sh0");
    issue(OP_SHR,  16'hABCD, 16'h0000, 1'b0, 16'hABCD, 1'b0, "shr_sh0");
    issue(OP_SRA,  16'h8421, 16'h0000, 1'b0, 16'h8421, 1'b0, "sra_sh0");
    issue(OP_ROL,  16'hABCD, 16'h0020, 1'b0, 16'hABCD, 1'b0, "rol_sh0");
    issue(OP_SRA,  16'h4000, 16'd2,    1'b0, 16'h1000, 1'b0, "sra_pos");

    // back-to-back sweep of all opcodes, A=C3A5 B=0F13 (sh=3) cin=1
    issue(OP_ADD,  16'hC3A5, 16'h0F13, 1'b1, 16'hD2B9, 1'b0, "sw_add");
    issue(OP_SUB,  16'hC3A5, 16'h0F13, 1'b1, 16'hB491, 1'b0, "sw_sub");
    issue(OP_AND,  16'hC3A5, 16'h0F13, 1'b1, 16'h0301, 1'b0, "sw_and");
    issue(OP_OR,   16'hC3A5, 16'h0F13, 1'b1, 16'hCFB7, 1'b0, "sw_or");
    issue(OP_XOR,  16'hC3A5, 16'h0F13, 1'b1, 16'hCCB6, 1'b0, "sw_xor");
    issue(OP_SHL,  16'hC3A5, 16'h0F13, 1'b1, 16'h1D28, 1'b0, "sw_shl");
    issue(OP_SHR,  16'hC3A5, 16'h0F13, 1'b1, 16'h1874, 1'b0, "sw_shr");
    issue(OP_SLTU, 16'hC3A5, 16'h0F13, 1'b1, 16'h0000, 1'b0, "sw_sltu");
    issue(OP_NOR,  16'hC3A5, 16'h0F13, 1'b1, 16'h3048, 1'b0, "sw_nor");
    issue(OP_NAND, 16'hC3A5, 16'h0F13, 1'b1, 16'hFCFE, 1'b0, "sw_nand");
    issue(OP_XNOR, 16'hC3A5, 16'h0F13, 1'b1, 16'h3349, 1'b0, "sw_xnor");
    issue(OP_NOT,  16'hC3A5, 16'h0F13, 1'b1, 16'h3C5A, 1'b0, "sw_not");
    issue(OP_SRA,  16'hC3A5, 16'h0F13, 1'b1, 16'hF874, 1'b0, "sw_sra");
    issue(OP_ROL,  16'hC3A5, 16'h0F13, 1'b1, 16'h1D2E, 1'b0, "sw_rol");
    issue(OP_PASA, 16'hC3A5, 16'h0F13, 1'b1, 16'hC3A5, 1'b0, "sw_pasa");
    issue(OP_PASB, 16'hC3A5, 16'h0F13, 1'b1, 16'h0F13, 1'b0, "sw_pasb");

    // carry-generating operands: cout must stay 0 outside ADD/SUB
    issue(OP_ADD,  16'hFFFF, 16'h0001, 1'b1, 16'h0001, 1'b1, "cy_add");
    issue(OP_AND,  16'hFFFF, 16'h0001, 1'b1, 16'h0001, 1'b0, "cy_and");
    issue(OP_OR,   16'hFFFF, 16'h0001, 1'b1, 16'hFFFF, 1'b0, "cy_or");
    issue(OP_SHL,  16'hFFFF, 16'h0001, 1'b1, 16'hFFFE, 1'b0, "cy_shl");
    issue(OP_SRA,  16'hFFFF, 16'h0001, 1'b1, 16'hFFFF, 1'b0, "cy_sra");
    issue(OP_PASB, 16'hFFFF, 16'h0001, 1'b1, 16'h0001, 1'b0, "cy_pasb");

    // only values present at the edge matter
    @(negedge clk);
    tb_vld = 1'b0;
    bus.op = OP_SUB; bus.A = 16'h0000; bus.B = 16'hFFFF; bus.cin = 1'b1;
    #2 drive(OP_XOR, 16'h5A5A, 16'h0FF0, 1'b0, 16'h55AA, 1'b0, "late_change");

    // reset mid-stream during an ADD sequence
    issue(OP_ADD, 16'd100, 16'd200, 1'b0, 16'd300, 1'b0, "pre_rst_add1");
    issue(OP_ADD, 16'd300, 16'd400, 1'b0, 16'd700, 1'b0, "pre_rst_add2");
    @(posedge clk);
    #2;
    rst    = 1'b1;
    tb_vld = 1'b0;
    exp_q.delete();
    name_q.delete();
    #1 check("reset_mid", {15'd0, bus.cout, bus.result}, 32'd0);
    @(posedge clk);
    #1 check("reset_hold", {15'd0, bus.cout, bus.result}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(OP_ADD, 16'd300, 16'd400, 1'b0, 16'd700, 1'b0, "post_mid_rst_add");
    issue(OP_ADD, 16'd1000, 16'd24, 1'b0, 16'd1024, 1'b0, "post_mid_rst_add2");

    idle();
    idle();
    idle();
    check("queue_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
